// File: rtl/mono_mode_ctrl.sv
// rtl/mono_mode_ctrl.sv - PS/2 Ctrl+Alt hotkey and CPU-write monochrome mode selector
module mono_mode_ctrl #(
  parameter int         TIMEOUT_CYC  = 95240,
  parameter logic [1:0] DEFAULT_MODE = 2'b00
) (
  input  logic       clk_kb,
  input  logic       rst_n,
  input  logic [7:0] kb_data,
  input  logic       kb_valid,
  input  logic       cpu_we,
  input  logic [7:0] cpu_din,
  output logic [1:0] monochrome_switcher,
  output logic       mode_chg
);

  localparam logic [16:0] TO_VAL = 17'(TIMEOUT_CYC);

  typedef enum logic [2:0] {S_IDLE, S_E0, S_F0, S_E0F0, S_SKIP} state_t;

  state_t      state, state_nxt, state_cur;
  logic [16:0] idle_cnt;
  logic [2:0]  skip_cnt, skip_nxt;
  logic        timeout;
  logic        ev_make, ev_break, ev_ext;
  logic        ctrl_l, ctrl_r, alt_l, alt_r, m_held;
  logic        hk;
  logic [1:0]  mode_nxt;

  // An abandoned prefix behaves exactly like IDLE, including for a byte arriving in that cycle
  assign timeout   = (state != S_IDLE) && (idle_cnt >= TO_VAL);
  assign state_cur = timeout ? S_IDLE : state;
  assign hk        = (ctrl_l | ctrl_r) & (alt_l | alt_r);

  // Prefix state, idle counter and Pause skip counter registers
  always_ff @(posedge clk_kb or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      skip_cnt <= 3'd0;
      idle_cnt <= 17'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      if (kb_valid || state_nxt == S_IDLE)
        idle_cnt <= 17'd0;
      else if (idle_cnt != TO_VAL)
        idle_cnt <= idle_cnt + 17'd1;
    end
  end

  // Prefix decoding: next state and make/break event generation
  always_comb begin
    state_nxt = timeout ? S_IDLE : state;
    skip_nxt  = skip_cnt;
    ev_make   = 1'b0;
    ev_break  = 1'b0;
    ev_ext    = 1'b0;
    if (kb_valid) begin
      case (state_cur)
        S_IDLE: begin
          case (kb_data)
            8'hE0: state_nxt = S_E0;
            8'hF0: state_nxt = S_F0;
            8'hE1: begin
              state_nxt = S_SKIP;
              skip_nxt  = 3'd7;
            end
            8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
            default: ev_make = 1'b1;
          endcase
        end
        S_E0: begin
          if (kb_data == 8'hF0)
            state_nxt = S_E0F0;
          else if (kb_data == 8'hE0)
            state_nxt = S_E0;
          else begin
            ev_make   = 1'b1;
            ev_ext    = 1'b1;
            state_nxt = S_IDLE;
          end
        end
        S_F0: begin
          ev_break  = 1'b1;
          state_nxt = S_IDLE;
        end
        S_E0F0: begin
          ev_break  = 1'b1;
          ev_ext    = 1'b1;
          state_nxt = S_IDLE;
        end
        S_SKIP: begin
          skip_nxt = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1)
            state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Modifier and M-held flags follow make/break events of their keys
  always_ff @(posedge clk_kb or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_l <= 1'b0;
      ctrl_r <= 1'b0;
      alt_l  <= 1'b0;
      alt_r  <= 1'b0;
      m_held <= 1'b0;
    end else if (ev_make || ev_break) begin
      case (kb_data)
        8'h14: if (ev_ext) ctrl_r <= ev_make; else ctrl_l <= ev_make;
        8'h11: if (ev_ext) alt_r  <= ev_make; else alt_l  <= ev_make;
        8'h3A: if (!ev_ext) m_held <= ev_make;
        default: ;
      endcase
    end
  end

  // Hotkey actions on non-extended makes; a CPU write overrides them
  always_comb begin
    mode_nxt = monochrome_switcher;
    if (ev_make && !ev_ext && hk) begin
      case (kb_data)
        8'h3A: if (!m_held) mode_nxt = monochrome_switcher + 2'd1;
        8'h16: mode_nxt = 2'b00;
        8'h1E: mode_nxt = 2'b01;
        8'h26: mode_nxt = 2'b10;
        8'h25: mode_nxt = 2'b11;
        default: ;
      endcase
    end
    if (cpu_we)
      mode_nxt = cpu_din[1:0];
  end

  // Registered mode output with a change pulse only on an actual value change
  always_ff @(posedge clk_kb or negedge rst_n) begin
    if (!rst_n) begin
      monochrome_switcher <= DEFAULT_MODE;
      mode_chg            <= 1'b0;
    end else begin
      monochrome_switcher <= mode_nxt;
      mode_chg            <= (mode_nxt != monochrome_switcher);
    end
  end

endmodule
